// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end with a small in-order fetch queue.
//
// Every cycle the PC register addresses instruction memory. The combinational
// response is pushed into the queue when there is room. An entry carrying an
// exception parks the unit in HALT with the PC frozen on the faulting address.
// Only a redirect or a reset returns the unit to FETCH.
//
// Optional feature: define IFETCH_MISALIGN_CHECK_EN to raise a local
// misaligned-fetch exception (code 0) whenever pc[1:0] != 0. When this is
// enabled, the memory response is ignored for that fetch.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   FQ_DEPTH  fetch-queue entries (power of two, >= 2)
//
// Ports:
//   clk, rst                          rising-edge clock, sync active-high reset
//   imem_addr                         fetch address (the PC register)
//   imem_instr                        instruction word for imem_addr
//   imem_exc_en/_code/_val            memory fetch fault for imem_addr
//   redirect_valid, redirect_pc       branch/trap/mret redirect
//   if_valid, if_ready                queue-head handshake towards decode
//   if_pc, if_instr                   head entry PC and instruction
//   if_exc_en/_code/_val              head entry exception fields
module ifetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_exc_en,
  output logic [3:0]  if_exc_code,
  output logic [63:0] if_exc_val
);

  localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [63:0]       pc, pc_next;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_next;
  logic [CNT_W-1:0]  count, count_next;

  // Queue storage: data only, never reset. Outputs are gated by if_valid.
  logic [63:0] q_pc       [FQ_DEPTH];
  logic [31:0] q_instr    [FQ_DEPTH];
  logic        q_exc_en   [FQ_DEPTH];
  logic [3:0]  q_exc_code [FQ_DEPTH];
  logic [63:0] q_exc_val  [FQ_DEPTH];

  logic        push, pop;
  logic [31:0] ent_instr;
  logic        ent_exc_en;
  logic [3:0]  ent_exc_code;
  logic [63:0] ent_exc_val;

  // Exception entries carry a NOP so decode never sees a faulted word.
  function automatic logic [31:0] fetch_word(input logic exc, input logic [31:0] word);
    return exc ? NOP_INSTR : word;
  endfunction

  // ---- Stage p0: build the candidate entry from the memory response ----
  always_comb begin
    ent_exc_en   = imem_exc_en;
    ent_exc_code = imem_exc_code;
    ent_exc_val  = imem_exc_val;
`ifdef IFETCH_MISALIGN_CHECK_EN
    if (pc[1:0] != 2'b00) begin
      ent_exc_en   = 1'b1;
      ent_exc_code = 4'd0;
      ent_exc_val  = pc;
    end
`endif
    ent_instr = fetch_word(ent_exc_en, imem_instr);
  end

  // A redirect wins over both queue operations in the same cycle.
  assign if_valid = (count != '0);
  assign pop      = if_valid && if_ready && !redirect_valid;
  assign push     = !rst && !redirect_valid && (state == FETCH) &&
                    ((count < DEPTH_C) || pop);

  // ---- Next-state: FSM, PC and queue bookkeeping ----
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    count_next  = count;
    if (redirect_valid) begin
      state_next  = FETCH;
      pc_next     = redirect_pc;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr + PTR_ONE;
        if (ent_exc_en) begin
          // Freeze on the faulting PC until redirected.
          state_next = HALT;
        end else begin
          pc_next = pc + 64'd4;
        end
      end
      if (pop) begin
        rd_ptr_next = rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  // ---- Stage p1: control registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      rd_ptr <= rd_ptr_next;
      wr_ptr <= wr_ptr_next;
      count  <= count_next;
    end
  end

  // ---- Stage p1: queue storage write ----
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]       <= pc;
      q_instr[wr_ptr]    <= ent_instr;
      q_exc_en[wr_ptr]   <= ent_exc_en;
      q_exc_code[wr_ptr] <= ent_exc_code;
      q_exc_val[wr_ptr]  <= ent_exc_val;
    end
  end

  // ---- Outputs: head entry, zero when the queue is empty ----
  assign imem_addr   = pc;
  assign if_pc       = if_valid ? q_pc[rd_ptr]       : 64'h0;
  assign if_instr    = if_valid ? q_instr[rd_ptr]    : 32'h0;
  assign if_exc_en   = if_valid ? q_exc_en[rd_ptr]   : 1'b0;
  assign if_exc_code = if_valid ? q_exc_code[rd_ptr] : 4'h0;
  assign if_exc_val  = if_valid ? q_exc_val[rd_ptr]  : 64'h0;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: table-driven and randomized bench for ifetch_unit with a
// queue-based reference model of the fetch rules.
module tb_ifetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          FQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_exc_en;
  logic [3:0]  if_exc_code;
  logic [63:0] if_exc_val;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr),
    .if_exc_en(if_exc_en), .if_exc_code(if_exc_code), .if_exc_val(if_exc_val)
  );

  // Instruction memory contents: a fixed hash of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h01000193) ^ 32'h5bd1e995;
  endfunction

  logic        fault_en = 1'b0;
  logic [63:0] fault_addr = 64'h0;
  logic        rnd_exc = 1'b0;

  always_comb begin
    imem_instr    = mem_word(imem_addr);
    imem_exc_en   = (fault_en && imem_addr == fault_addr) || rnd_exc;
    imem_exc_code = 4'd1;
    imem_exc_val  = imem_addr;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of entries plus PC and a halted flag.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic [3:0]  code;
    logic [63:0] val;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc;
  bit          m_halt;
  bit          model_ok = 0;

  task automatic model_check();
    ent_t h;
    if (!model_ok) return;
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", {63'h0, if_valid}, {63'h0, mq.size() != 0});
    if (mq.size() != 0) h = mq[0];
    else h = '{pc: 64'h0, instr: 32'h0, exc: 1'b0, code: 4'h0, val: 64'h0};
    chk("if_pc", if_pc, h.pc);
    chk("if_instr", {32'h0, if_instr}, {32'h0, h.instr});
    chk("if_exc_en", {63'h0, if_exc_en}, {63'h0, h.exc});
    chk("if_exc_code", {60'h0, if_exc_code}, {60'h0, h.code});
    chk("if_exc_val", if_exc_val, h.val);
  endtask

  task automatic model_update();
    ent_t e;
    bit do_pop, do_push;
    if (rst) begin
      mq.delete(); m_pc = RESET_PC; m_halt = 0;
    end else if (redirect_valid) begin
      mq.delete(); m_pc = redirect_pc; m_halt = 0;
    end else begin
      do_pop  = (mq.size() != 0) && if_ready;
      do_push = !m_halt && ((mq.size() < FQ_DEPTH) || do_pop);
      e.pc    = m_pc;
      e.exc   = (fault_en && m_pc == fault_addr) || rnd_exc;
      e.code  = 4'd1;
      e.val   = m_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
      if (m_pc % 4 != 0) begin
        e.exc = 1'b1; e.code = 4'd0; e.val = m_pc;
      end
`endif
      e.instr = e.exc ? 32'h00000013 : mem_word(m_pc);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(e);
        if (e.exc) m_halt = 1;
        else m_pc = m_pc + 64'd4;
      end
    end
    model_ok = 1;
  endtask

  // Inputs are set at posedge+1; outputs checked at posedge+4; then the edge.
  task automatic step();
    #3;
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          rst;
    bit          ready;
    bit          exp_valid;
    logic [63:0] exp_pc;
    logic [63:0] exp_addr;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1, 1, 0, 64'h0,  64'h0};
    vecs[1]  = '{0, 1, 0, 64'h0,  64'h0};
    vecs[2]  = '{0, 1, 1, 64'h0,  64'h4};
    vecs[3]  = '{0, 1, 1, 64'h4,  64'h8};
    vecs[4]  = '{0, 1, 1, 64'h8,  64'hC};
    vecs[5]  = '{0, 1, 1, 64'hC,  64'h10};
    vecs[6]  = '{1, 0, 1, 64'h10, 64'h14};
    vecs[7]  = '{0, 0, 0, 64'h0,  64'h0};
    vecs[8]  = '{0, 0, 1, 64'h0,  64'h4};
    vecs[9]  = '{0, 0, 1, 64'h0,  64'h8};
    vecs[10] = '{0, 0, 1, 64'h0,  64'h8};
    vecs[11] = '{0, 0, 1, 64'h0,  64'h8};
    vecs[12] = '{0, 1, 1, 64'h0,  64'h8};
    vecs[13] = '{0, 1, 1, 64'h4,  64'hC};
    vecs[14] = '{0, 1, 1, 64'h8,  64'h10};

    rst = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0;
    @(posedge clk); #1;
    step();

    // Straight-line fetch, reset, backpressure and release.
    for (int i = 0; i < 15; i++) begin
      rst = vecs[i].rst;
      if_ready = vecs[i].ready;
      chk($sformatf("tbl%0d_valid", i), {63'h0, if_valid}, {63'h0, vecs[i].exp_valid});
      chk($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("tbl%0d_pc", i), if_pc, vecs[i].exp_valid ? vecs[i].exp_pc : 64'h0);
      chk($sformatf("tbl%0d_instr", i), {32'h0, if_instr},
          {32'h0, vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'h0});
      step();
    end
    rst = 1'b0;

    // Redirect while the queue is full.
    if_ready = 1'b0;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid0", {63'h0, if_valid}, 64'h0);
    chk("redir_addr", imem_addr, 64'h100);
    step();
    chk("redir_valid1", {63'h0, if_valid}, 64'h1);
    chk("redir_pc", if_pc, 64'h100);

    // Access fault parks the unit until a redirect.
    fault_en = 1'b1; fault_addr = 64'h2000;
    redirect_valid = 1'b1; redirect_pc = 64'h2000;
    step();
    redirect_valid = 1'b0;
    step();
    chk("fault_exc_en", {63'h0, if_exc_en}, 64'h1);
    chk("fault_code", {60'h0, if_exc_code}, 64'h1);
    chk("fault_val", if_exc_val, 64'h2000);
    chk("fault_instr", {32'h0, if_instr}, 64'h13);
    chk("fault_addr", imem_addr, 64'h2000);
    if_ready = 1'b1;
    repeat (3) step();
    chk("halt_addr", imem_addr, 64'h2000);
    chk("halt_drained", {63'h0, if_valid}, 64'h0);
    redirect_valid = 1'b1; redirect_pc = 64'h80;
    step();
    redirect_valid = 1'b0; fault_en = 1'b0;
    step();
    chk("resume_pc", if_pc, 64'h80);
    chk("resume_addr", imem_addr, 64'h84);

    // Reset with the queue full.
    if_ready = 1'b0;
    repeat (3) step();
    chk("full_valid", {63'h0, if_valid}, 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", {63'h0, if_valid}, 64'h0);
    chk("midrst_addr", imem_addr, RESET_PC);

`ifdef IFETCH_MISALIGN_CHECK_EN
    redirect_valid = 1'b1; redirect_pc = 64'h102;
    step();
    redirect_valid = 1'b0;
    step();
    chk("mis_exc_en", {63'h0, if_exc_en}, 64'h1);
    chk("mis_code", {60'h0, if_exc_code}, 64'h0);
    chk("mis_val", if_exc_val, 64'h102);
    chk("mis_instr", {32'h0, if_instr}, 64'h13);
    repeat (2) step();
    chk("mis_halt_addr", imem_addr, 64'h102);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      if_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) redirect_pc[1:0] = 2'b00;
      rnd_exc        = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0; redirect_valid = 1'b0; rnd_exc = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC loaded on reset.
REQ-002 Parameter FQ_DEPTH, default 2: fetch-queue entries; power of two, at least 2.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 imem_addr  out  64  fetch PC to instruction memory; driven directly from the PC register.
REQ-006 imem_instr  in  32  instruction word for imem_addr; combinational, same cycle.
REQ-007 imem_exc_en / imem_exc_code / imem_exc_val  in  1/4/64  memory fetch fault (access fault code 1, faulting PC).
REQ-008 redirect_valid / redirect_pc  in  1/64  branch, trap or mret redirect request.
REQ-009 if_valid  out  1  queue head is valid.
REQ-010 if_ready  in  1  decode accepts the head this cycle.
REQ-011 if_pc / if_instr  out  64/32  PC and instruction word of the head entry.
REQ-012 if_exc_en / if_exc_code / if_exc_val  out  1/4/64  exception fields of the head entry.

Function
REQ-013 Two states: FETCH and HALT.
REQ-014 Pop: occurs when if_valid and if_ready are both high.
REQ-015 Push, in FETCH only: occurs when count < FQ_DEPTH, or count == FQ_DEPTH and a pop occurs in the same cycle.
  - Entry written: {pc, imem_instr, imem_exc_en, imem_exc_code, imem_exc_val}.
  - On push: pc <= pc + 4, modulo 2^64.
REQ-016 Exception entry: a pushed entry with exc_en=1 stores instruction 32'h00000013.
  - State <= HALT; pc is not advanced.
REQ-017 HALT: no pushes; imem_addr holds the faulting PC; queued entries still drain normally.
REQ-018 Redirect has priority over push and pop.
  - Queue emptied, pc <= redirect_pc, state <= FETCH.
  - No push and no pop that cycle; if_valid is 0 on the next cycle.
REQ-019 Fetch latency: an instruction fetched at cycle N is presented at the head on cycle N+1 when the queue was empty.
REQ-020 Sustained throughput: one instruction per cycle while if_ready stays high.
REQ-021 if_valid = (count != 0).
  - Head fields are held stable while if_valid=1 and if_ready=0.
REQ-022 Order: entries leave in the order they were pushed; pointers wrap modulo FQ_DEPTH.
REQ-023 Full with no pop: no push, and pc holds.
REQ-024 Empty with if_ready=1: no pop, and count stays 0.

Reset
REQ-025 While rst=1, on each rising edge:
  - pc <= RESET_PC;
  - count, read pointer and write pointer <= 0;
  - state <= FETCH.
REQ-026 Output values during and after reset:
  - if_valid=0;
  - if_pc, if_instr and exception outputs = 0;
  - imem_addr = RESET_PC.
REQ-027 No push occurs in a cycle where rst=1.
REQ-028 Reset asserted mid-operation discards all queued entries and any pending HALT.

Configuration
REQ-029 Macro IFETCH_MISALIGN_CHECK_EN defined: when pc[1:0] != 0, the unit does not use the memory response. Instead it:
  - pushes a local exception entry: exc_en=1, exc_code=4'd0, exc_val=pc, instruction 32'h00000013;
  - enters HALT.
REQ-030 Macro IFETCH_MISALIGN_CHECK_EN undefined: no alignment check; the memory response is pushed unchanged.

Verification
REQ-031 Straight-line fetch: RESET_PC=0, memory words 0..3 = A,B,C,D, if_ready=1 constantly.
  - Required: if_instr A,B,C,D on consecutive cycles starting 1 cycle after reset release.
  - Required: if_pc 0,4,8,C.
REQ-032 Backpressure: if_ready=0 for 5 cycles.
  - Required: after 2 pushes, imem_addr holds at 0x8 and if_instr holds A.
  - On release: A,B,C delivered with no loss and no duplicates.
REQ-033 Redirect: redirect_valid=1 with redirect_pc=0x100 while the queue is full.
  - Required: next cycle if_valid=0.
  - Following cycle: if_pc=0x100.
REQ-034 Access fault: imem_exc_en=1, code 1, val 0x2000 at pc=0x2000.
  - Required: head shows if_exc_en=1, code 1, val 0x2000, instr 0x00000013.
  - Required: imem_addr stays 0x2000 until a redirect to 0x80 resumes fetch at 0x80.
REQ-035 Mid-operation reset: rst asserted with the queue full.
  - Required: next cycle if_valid=0 and imem_addr=RESET_PC.
REQ-036 With IFETCH_MISALIGN_CHECK_EN defined, redirect to 0x102.
  - Required: head if_exc_en=1, code 0, val 0x102; state HALT.
